// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared types, limits and helpers for the interrupt line
//                arbiter and its priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Arbiter request-tracking states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int IRQ_MAX_LINES = 32;

    // Width of a line index for an n-line arbiter
    function automatic int irq_id_w(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational lowest-index-first priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_line_arbiter
//  Description : Latches peripheral interrupt lines as pending, applies a
//                software enable mask and presents one prioritised request,
//                tracking it through take and retire.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_line_arbiter
    import irq_pkg::*;
#(
    parameter int                 N_LINES   = 16,
    parameter logic [N_LINES-1:0] EDGE_MASK = 16'h00FF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_LINES-1:0]            irq_lines_i,
    input  logic                          mask_we_i,
    input  logic [N_LINES-1:0]            mask_wdata_i,
    input  logic                          irq_taken_i,
    input  logic                          irq_ret_i,
    output logic                          irq_req_o,
    output logic [irq_id_w(N_LINES)-1:0]  irq_id_o,
    output logic [N_LINES-1:0]            pending_o,
    output logic [N_LINES-1:0]            mask_o
);

    localparam int ID_W = irq_id_w(N_LINES);

    irq_state_t         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic [N_LINES-1:0] mask_q, mask_d;
    logic [N_LINES-1:0] w_elig;
    logic [N_LINES-1:0] w_elig_next;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_take;

    // A take only counts while a request is actually outstanding
    assign w_take = (state_q == REQ) && irq_taken_i;
    assign mask_d = mask_we_i ? mask_wdata_i : mask_q;

    // Per-line pending logic: edge lines keep their own previous sample
    generate
        for (genvar n = 0; n < N_LINES; n++) begin : g_line
            if (EDGE_MASK[n]) begin : g_edge
                logic prev_q;
                logic w_clr;

                assign w_clr     = w_take && (id_q == ID_W'(n));
                // A new edge beats a simultaneous take-clear
                assign pend_d[n] = (irq_lines_i[n] & ~prev_q) | (pend_q[n] & ~w_clr);

                // Previous-cycle sample for rising-edge detection
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        prev_q <= 1'b0;
                    end else begin
                        prev_q <= irq_lines_i[n];
                    end
                end
            end else begin : g_level
                assign pend_d[n] = irq_lines_i[n];
            end
        end
    endgenerate

    // Winner selection uses the registered view; withdrawal looks at the
    // values being loaded this cycle so a drop or mask-off at t clears the
    // request at t+1 rather than t+2.
    assign w_elig      = pend_q & mask_q;
    assign w_elig_next = pend_d & mask_d;

    irq_prio_enc #(
        .WIDTH (N_LINES),
        .IDX_W (ID_W)
    ) u_prio (
        .vec_i   (w_elig),
        .valid_o (w_win_valid),
        .idx_o   (w_win_idx)
    );

    // State, latched id, pending and enable registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state logic; the id only moves on IDLE -> REQ
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (w_win_valid) begin
                    state_d = REQ;
                    id_d    = w_win_idx;
                end
            end
            REQ: begin
                if (irq_taken_i) begin
                    state_d = SERVICE;
                end else if (!w_elig_next[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (irq_ret_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq_req_o = (state_q == REQ);
    assign irq_id_o  = id_q;
    assign pending_o = pend_q;
    assign mask_o    = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_line_arbiter
//  Description : Self-checking bench for irq_line_arbiter with an expected-id
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_line_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_lines;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        irq_taken;
    logic        irq_ret;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic [15:0] pending;
    logic [15:0] mask;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    irq_line_arbiter #(
        .N_LINES   (16),
        .EDGE_MASK (16'h00FF)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_lines_i  (irq_lines),
        .mask_we_i    (mask_we),
        .mask_wdata_i (mask_wdata),
        .irq_taken_i  (irq_taken),
        .irq_ret_i    (irq_ret),
        .irq_req_o    (irq_req),
        .irq_id_o     (irq_id),
        .pending_o    (pending),
        .mask_o       (mask)
    );

    always #5 clk = ~clk;

    // Drive/sample point: 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_lines(input logic [15:0] v);
        irq_lines = v;
        tick();
        irq_lines = 16'h0000;
    endtask

    task automatic write_mask(input logic [15:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic take();
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
    endtask

    task automatic retire();
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
    endtask

    task automatic pop_exp(output int v);
        if (exp_q.size() == 0) begin
            v = -1;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (irq_req) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", irq_req); end
        checks++; if (irq_id !== 4'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        checks++; if (pending !== 16'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0000", pending); end
        checks++; if (mask !== 16'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0000", mask); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_edge_single();
        int e;
        write_mask(16'h0004);
        checks++; if (mask !== 16'h0004) begin failures++; $display("FAIL single_mask got=%h exp=0004", mask); end
        exp_q.push_back(2);
        pulse_lines(16'h0004);
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL single_early_req got=%b exp=0", irq_req); end
        checks++; if (pending[2] !== 1'b1) begin failures++; $display("FAIL single_pend_set got=%b exp=1", pending[2]); end
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", irq_req); end
        checks++; if (int'(irq_id) !== e) begin failures++; $display("FAIL single_id got=%0d exp=%0d", irq_id, e); end
        take();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL single_take_req got=%b exp=0", irq_req); end
        checks++; if (pending[2] !== 1'b0) begin failures++; $display("FAIL single_pend_clr got=%b exp=0", pending[2]); end
        retire();
        repeat (3) tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL single_no_rereq got=%b exp=0", irq_req); end
    endtask

    task automatic test_two_edges();
        int e;
        bit ok;
        write_mask(16'hFFFF);
        exp_q.push_back(3);
        exp_q.push_back(5);
        pulse_lines(16'h0028);
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL two_first req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        take();
        retire();
        checks++; if (pending[5] !== 1'b1) begin failures++; $display("FAIL two_pend5 got=%b exp=1", pending[5]); end
        wait_req(ok);
        pop_exp(e);
        checks++; if (!ok || int'(irq_id) !== e) begin failures++; $display("FAIL two_second req_seen=%0d id=%0d exp_id=%0d", ok, irq_id, e); end
        take();
        retire();
    endtask

    task automatic test_level();
        int e;
        irq_lines = 16'h0200;
        exp_q.push_back(9);
        tick();
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL level_req req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        take();
        checks++; if (irq_req !== 1'b0 || pending[9] !== 1'b1) begin failures++; $display("FAIL level_take req=%b pend9=%b exp req=0 pend9=1", irq_req, pending[9]); end
        retire();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL level_ret_gap got=%b exp=0", irq_req); end
        exp_q.push_back(9);
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL level_rereq req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        irq_lines = 16'h0000;
        tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL level_withdraw got=%b exp=0", irq_req); end
        tick();
        checks++; if (pending !== 16'h0000) begin failures++; $display("FAIL level_pend_drop got=%h exp=0000", pending); end
    endtask

    task automatic test_take_vs_mask();
        int e;
        exp_q.push_back(4);
        pulse_lines(16'h0010);
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL tvm_req req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        irq_taken  = 1'b1;
        mask_we    = 1'b1;
        mask_wdata = 16'h0000;
        tick();
        irq_taken  = 1'b0;
        mask_we    = 1'b0;
        checks++; if (irq_req !== 1'b0 || pending[4] !== 1'b0) begin failures++; $display("FAIL tvm_take req=%b pend4=%b exp 0 0", irq_req, pending[4]); end
        checks++; if (mask !== 16'h0000) begin failures++; $display("FAIL tvm_mask got=%h exp=0000", mask); end
        retire();
        write_mask(16'hFFFF);
    endtask

    task automatic test_no_preempt();
        int e;
        exp_q.push_back(6);
        pulse_lines(16'h0040);
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL np_req req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        pulse_lines(16'h0002);
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd6) begin failures++; $display("FAIL np_hold_req req=%b id=%0d exp 1 6", irq_req, irq_id); end
        take();
        checks++; if (irq_req !== 1'b0 || irq_id !== 4'd6 || pending[1] !== 1'b1) begin failures++; $display("FAIL np_service req=%b id=%0d pend1=%b exp 0 6 1", irq_req, irq_id, pending[1]); end
        tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL np_service_hold got=%b exp=0", irq_req); end
        exp_q.push_back(1);
        retire();
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL np_after_ret req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        take();
        retire();
    endtask

    task automatic test_reset_in_service();
        int e;
        exp_q.push_back(7);
        pulse_lines(16'h0080);
        tick();
        pop_exp(e);
        checks++; if (irq_req !== 1'b1 || int'(irq_id) !== e) begin failures++; $display("FAIL rs_req req=%b id=%0d exp_id=%0d", irq_req, irq_id, e); end
        take();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (irq_req !== 1'b0 || irq_id !== 4'd0) begin failures++; $display("FAIL rs_outputs req=%b id=%0d exp 0 0", irq_req, irq_id); end
        checks++; if (pending !== 16'h0 || mask !== 16'h0) begin failures++; $display("FAIL rs_regs pend=%h mask=%h exp 0000 0000", pending, mask); end
        write_mask(16'hFFFF);
        retire();
        repeat (3) tick();
        checks++; if (irq_req !== 1'b0 || irq_id !== 4'd0) begin failures++; $display("FAIL rs_stray_ret req=%b id=%0d exp 0 0", irq_req, irq_id); end
    endtask

    initial begin
        rst        = 1'b1;
        irq_lines  = 16'h0000;
        mask_we    = 1'b0;
        mask_wdata = 16'h0000;
        irq_taken  = 1'b0;
        irq_ret    = 1'b0;

        test_reset();
        test_edge_single();
        test_two_edges();
        test_level();
        test_take_vs_mask();
        test_no_preempt();
        test_reset_in_service();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
